// File: rtl/fft16_bin_stream.sv
// Streams a captured 16-bin complex FFT frame out as one |X|^2 power value per beat.
// Optional frame peak tracking is compiled in with `define FFT16_PEAK_EN.
module fft16_bin_stream #(
    parameter int SHIFT = 0,
    parameter int PW    = 40 - SHIFT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_vld,
    output logic          frame_rdy,
    input  logic [639:0]  bin_in,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [PW-1:0] m_power,
    output logic [3:0]    m_bin,
    output logic          m_last
`ifdef FFT16_PEAK_EN
    ,
    output logic          peak_vld,
    output logic [3:0]    peak_bin,
    output logic [PW-1:0] peak_power
`endif
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state_q, state_d;
    logic [15:0][39:0]    frame_q, frame_d;
    logic                 m_valid_q, m_valid_d;
    logic [3:0]           m_bin_q, m_bin_d;
    logic                 m_last_q, m_last_d;
    logic [PW-1:0]        m_power_q, m_power_d;
    logic                 accept;
    logic                 advance;
    logic [3:0]           next_bin;

    // Squares are non-negative and at most 2^38, so their 40-bit sum cannot overflow.
    function automatic logic [39:0] bin_power(input logic [39:0] b);
        logic signed [39:0] re_x, im_x, re_sq, im_sq;
        re_x  = {{20{b[19]}}, b[19:0]};
        im_x  = {{20{b[39]}}, b[39:20]};
        re_sq = re_x * re_x;
        im_sq = im_x * im_x;
        return $unsigned(re_sq) + $unsigned(im_sq);
    endfunction

    function automatic logic [PW-1:0] scale(input logic [39:0] p);
        return PW'(p >> SHIFT);
    endfunction

    always_comb begin
        frame_rdy = (state_q == IDLE) || (m_valid_q && m_ready && m_last_q);
        accept    = frame_vld && frame_rdy;
        advance   = m_valid_q && m_ready;
        next_bin  = m_bin_q + 4'd1;

        state_d   = state_q;
        frame_d   = frame_q;
        m_valid_d = m_valid_q;
        m_bin_d   = m_bin_q;
        m_last_d  = m_last_q;
        m_power_d = m_power_q;

        // A new frame takes priority so back-to-back frames stream with no bubble.
        if (accept) begin
            state_d   = STREAM;
            frame_d   = bin_in;
            m_valid_d = 1'b1;
            m_bin_d   = 4'd0;
            m_last_d  = 1'b0;
            m_power_d = scale(bin_power(bin_in[39:0]));
        end else if (advance) begin
            if (m_last_q) begin
                state_d   = IDLE;
                m_valid_d = 1'b0;
            end else begin
                m_bin_d   = next_bin;
                m_last_d  = (next_bin == 4'd15);
                m_power_d = scale(bin_power(frame_q[next_bin]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            m_valid_q <= 1'b0;
            m_bin_q   <= 4'd0;
            m_last_q  <= 1'b0;
            m_power_q <= '0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            m_valid_q <= m_valid_d;
            m_bin_q   <= m_bin_d;
            m_last_q  <= m_last_d;
            m_power_q <= m_power_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_bin   = m_bin_q;
    assign m_last  = m_last_q;
    assign m_power = m_power_q;

`ifdef FFT16_PEAK_EN
    logic [PW-1:0] run_max_q, run_max_d;
    logic [3:0]    run_bin_q, run_bin_d;
    logic          peak_vld_q, peak_vld_d;
    logic [3:0]    peak_bin_q, peak_bin_d;
    logic [PW-1:0] peak_power_q, peak_power_d;
    logic [PW-1:0] cand_power;
    logic [3:0]    cand_bin;

    // Strict greater-than in bin order keeps the lowest index on ties.
    always_comb begin
        cand_power   = run_max_q;
        cand_bin     = run_bin_q;
        run_max_d    = run_max_q;
        run_bin_d    = run_bin_q;
        peak_vld_d   = 1'b0;
        peak_bin_d   = peak_bin_q;
        peak_power_d = peak_power_q;

        if (m_power_q > run_max_q) begin
            cand_power = m_power_q;
            cand_bin   = m_bin_q;
        end

        if (advance) begin
            run_max_d = cand_power;
            run_bin_d = cand_bin;
            if (m_last_q) begin
                peak_vld_d   = 1'b1;
                peak_bin_d   = cand_bin;
                peak_power_d = cand_power;
            end
        end

        if (accept) begin
            run_max_d = '0;
            run_bin_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_max_q    <= '0;
            run_bin_q    <= 4'd0;
            peak_vld_q   <= 1'b0;
            peak_bin_q   <= 4'd0;
            peak_power_q <= '0;
        end else begin
            run_max_q    <= run_max_d;
            run_bin_q    <= run_bin_d;
            peak_vld_q   <= peak_vld_d;
            peak_bin_q   <= peak_bin_d;
            peak_power_q <= peak_power_d;
        end
    end

    assign peak_vld   = peak_vld_q;
    assign peak_bin   = peak_bin_q;
    assign peak_power = peak_power_q;
`endif

endmodule

// File: tb/tb_fft16_bin_stream.sv
// Bench for fft16_bin_stream: two instances (SHIFT=0 and SHIFT=8) share stimulus and are
// compared each cycle against a frame-level reference model.
module tb_fft16_bin_stream;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_vld;
    logic          m_ready;
    logic [639:0]  bin_in;

    logic          frame_rdy0, m_valid0, m_last0;
    logic [3:0]    m_bin0;
    logic [39:0]   m_power0;
    logic          frame_rdy8, m_valid8, m_last8;
    logic [3:0]    m_bin8;
    logic [31:0]   m_power8;
`ifdef FFT16_PEAK_EN
    logic          peak_vld0, peak_vld8;
    logic [3:0]    peak_bin0, peak_bin8;
    logic [39:0]   peak_power0;
    logic [31:0]   peak_power8;
`endif

    fft16_bin_stream #(.SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .frame_vld(frame_vld), .frame_rdy(frame_rdy0),
        .bin_in(bin_in), .m_valid(m_valid0), .m_ready(m_ready),
        .m_power(m_power0), .m_bin(m_bin0), .m_last(m_last0)
`ifdef FFT16_PEAK_EN
        , .peak_vld(peak_vld0), .peak_bin(peak_bin0), .peak_power(peak_power0)
`endif
    );

    fft16_bin_stream #(.SHIFT(8)) u_dut8 (
        .clk(clk), .rst(rst), .frame_vld(frame_vld), .frame_rdy(frame_rdy8),
        .bin_in(bin_in), .m_valid(m_valid8), .m_ready(m_ready),
        .m_power(m_power8), .m_bin(m_bin8), .m_last(m_last8)
`ifdef FFT16_PEAK_EN
        , .peak_vld(peak_vld8), .peak_bin(peak_bin8), .peak_power(peak_power8)
`endif
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    int     in_re[16], in_im[16];
    int     ex_re[16], ex_im[16];
    bit     ex_valid = 1'b0;
    int     ex_idx = 0;
    bit     ex_pk_vld = 1'b0;
    int     ex_pk_bin[2];
    longint ex_pk_pow[2];

    function automatic int sx20(input logic [19:0] v);
        return int'($signed(v));
    endfunction

    function automatic longint pw(input int re, input int im, input int sh);
        longint p;
        p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
        return p >> sh;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_frame();
        for (int k = 0; k < 16; k++) begin
            bin_in[40*k +: 20]    = in_re[k][19:0];
            bin_in[40*k+20 +: 20] = in_im[k][19:0];
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 16; k++) begin
            in_re[k] = sx20(20'($urandom()));
            in_im[k] = sx20(20'($urandom()));
        end
        drive_frame();
    endtask

    function automatic bit exp_rdy();
        return !ex_valid || (m_ready && ex_idx == 15);
    endfunction

    task automatic compute_peak();
        for (int s = 0; s < 2; s++) begin
            longint best;
            int     sh;
            sh = (s == 0) ? 0 : 8;
            best = -1;
            for (int k = 0; k < 16; k++) begin
                if (pw(ex_re[k], ex_im[k], sh) > best) begin
                    best         = pw(ex_re[k], ex_im[k], sh);
                    ex_pk_bin[s] = k;
                end
            end
            ex_pk_pow[s] = best;
        end
    endtask

    task automatic check_output();
        bit rdy;
        rdy = exp_rdy();
        chk("frame_rdy0", 64'(frame_rdy0), 64'(rdy));
        chk("frame_rdy8", 64'(frame_rdy8), 64'(rdy));
        chk("m_valid0", 64'(m_valid0), 64'(ex_valid));
        chk("m_valid8", 64'(m_valid8), 64'(ex_valid));
        if (ex_valid) begin
            chk("m_bin0", 64'(m_bin0), 64'(ex_idx));
            chk("m_bin8", 64'(m_bin8), 64'(ex_idx));
            chk("m_last0", 64'(m_last0), 64'(ex_idx == 15));
            chk("m_last8", 64'(m_last8), 64'(ex_idx == 15));
            chk("m_power0", 64'(m_power0), 64'(pw(ex_re[ex_idx], ex_im[ex_idx], 0)));
            chk("m_power8", 64'(m_power8), 64'(pw(ex_re[ex_idx], ex_im[ex_idx], 8)));
        end
`ifdef FFT16_PEAK_EN
        chk("peak_vld0", 64'(peak_vld0), 64'(ex_pk_vld));
        chk("peak_vld8", 64'(peak_vld8), 64'(ex_pk_vld));
        if (ex_pk_vld) begin
            chk("peak_bin0", 64'(peak_bin0), 64'(ex_pk_bin[0]));
            chk("peak_bin8", 64'(peak_bin8), 64'(ex_pk_bin[1]));
            chk("peak_power0", 64'(peak_power0), 64'(ex_pk_pow[0]));
            chk("peak_power8", 64'(peak_power8), 64'(ex_pk_pow[1]));
        end
`endif
    endtask

    // Frame-level model: a frame is a list of 16 beats consumed one per accepted handshake.
    task automatic model_update();
        bit rdy;
        rdy = exp_rdy();
        ex_pk_vld = 1'b0;
        if (rst) begin
            ex_valid = 1'b0;
            ex_idx   = 0;
        end else begin
            if (ex_valid && m_ready) begin
                if (ex_idx == 15) begin
                    compute_peak();
                    ex_pk_vld = 1'b1;
                    ex_valid  = 1'b0;
                end else begin
                    ex_idx++;
                end
            end
            if (frame_vld && rdy) begin
                ex_re    = in_re;
                ex_im    = in_im;
                ex_valid = 1'b1;
                ex_idx   = 0;
            end
        end
    endtask

    task automatic tick();
        #1;
        check_output();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        frame_vld = 1'b1;
        m_ready   = 1'b1;
        rand_frame();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid0), 64'd0);
        chk("rst_m_bin", 64'(m_bin0), 64'd0);
        chk("rst_m_power", 64'(m_power0), 64'd0);
        chk("rst_m_last", 64'(m_last8), 64'd0);
        chk("rst_m_power8", 64'(m_power8), 64'd0);
`ifdef FFT16_PEAK_EN
        chk("rst_peak_vld", 64'(peak_vld0), 64'd0);
        chk("rst_peak_bin", 64'(peak_bin0), 64'd0);
        chk("rst_peak_power", 64'(peak_power0), 64'd0);
`endif
        tick();
        rst       = 1'b0;
        frame_vld = 1'b0;
        repeat (3) tick();

        $display("[TB] ramp frame");
        for (int k = 0; k < 16; k++) begin
            in_re[k] = k;
            in_im[k] = k;
        end
        drive_frame();
        frame_vld = 1'b1;
        tick();
        frame_vld = 1'b0;
        repeat (19) tick();

        $display("[TB] extreme values frame");
        rand_frame();
        in_re[0] = -524288; in_im[0] = 0;
        in_re[1] = -524288; in_im[1] = -524288;
        in_re[3] = 3;       in_im[3] = 4;
        drive_frame();
        frame_vld = 1'b1;
        tick();
        frame_vld = 1'b0;
        chk("max_bin0_pow", 64'(m_power0), 64'h40_0000_0000);
        chk("max_bin0_pow8", 64'(m_power8), 64'h4000_0000);
        tick();
        chk("max_bin1_pow", 64'(m_power0), 64'h80_0000_0000);
        chk("max_bin1_pow8", 64'(m_power8), 64'h8000_0000);
        repeat (18) tick();

        $display("[TB] backpressure 1,0,0,1");
        rand_frame();
        frame_vld = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            m_ready = (i < 2) ? 1'b1 : ((i % 4) == 0 || (i % 4) == 1);
            rand_frame();
            frame_vld = (i > 30);
            tick();
        end
        frame_vld = 1'b0;
        m_ready   = 1'b1;
        repeat (18) tick();

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            m_ready   = ($urandom_range(0, 3) != 0);
            frame_vld = $urandom_range(0, 1) == 1;
            rand_frame();
            tick();
        end
        frame_vld = 1'b0;
        m_ready   = 1'b1;
        repeat (18) tick();

        $display("[TB] back-to-back frames");
        frame_vld = 1'b1;
        for (int i = 0; i < 48; i++) begin
            rand_frame();
            tick();
        end
        frame_vld = 1'b0;
        repeat (18) tick();

        $display("[TB] reset mid-stream");
        rand_frame();
        frame_vld = 1'b1;
        tick();
        frame_vld = 1'b0;
        for (int i = 0; i < 20 && !(ex_valid && ex_idx == 7); i++) tick();
        chk("rst_at_beat", 64'(m_bin0), 64'd7);
        rst       = 1'b1;
        frame_vld = 1'b1;
        rand_frame();
        tick();
        rst       = 1'b0;
        frame_vld = 1'b0;
        chk("post_rst_valid", 64'(m_valid0), 64'd0);
        tick();
        rand_frame();
        frame_vld = 1'b1;
        tick();
        frame_vld = 1'b0;
        repeat (18) tick();

        $display("[TB] peak tie frame");
        for (int k = 0; k < 16; k++) begin
            in_re[k] = int'($urandom_range(0, 40)) - 20;
            in_im[k] = int'($urandom_range(0, 40)) - 20;
        end
        in_re[5]  = 30; in_im[5]  = 10;
        in_re[11] = 10; in_im[11] = 30;
        drive_frame();
        frame_vld = 1'b1;
        tick();
        frame_vld = 1'b0;
        repeat (18) tick();
`ifdef FFT16_PEAK_EN
        chk("peak_tie_bin", 64'(peak_bin0), 64'd5);
        chk("peak_tie_power", 64'(peak_power0), 64'd1000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft16_bin_stream.md
Name: fft16_bin_stream

Overview:
Downstream stage of the 16-point FFT. Captures one parallel frame of 16 complex bins, each {imag[19:0], real[19:0]} signed. Streams the bins out one per beat as power values |X|^2 = re^2 + im^2 on a valid/ready interface. Feeds the spectrum-analysis and buffering logic that consumes one bin per clock.

Parameters:
SHIFT, 0, right-shift (truncating) applied to the 40-bit power before output; legal range 0..16.
PW, 40-SHIFT, derived output power width; do not override.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
frame_vld  in  1  bin_in holds a complete FFT frame
frame_rdy  out  1  block can accept a frame this cycle
bin_in  in  640  bin k at [40k+39:40k]; within a bin, imag[39:20], real[19:0], two's complement
m_valid  out  1  output beat valid
m_ready  in  1  downstream accepts beat
m_power  out  PW  (re^2+im^2) >> SHIFT, unsigned
m_bin  out  4  bin index of current beat
m_last  out  1  high on bin 15 beat
peak_vld  out  1  (FFT16_PEAK_EN only) one-cycle pulse with frame peak
peak_bin  out  4  (FFT16_PEAK_EN only) index of max-power bin
peak_power  out  PW  (FFT16_PEAK_EN only) max power of frame

Behaviour:
- States: IDLE, STREAM. Reset values: state IDLE; m_valid, m_last, m_bin, m_power, peak_vld, peak_bin, peak_power all 0.
- frame_rdy is combinational: 1 in IDLE, or in STREAM during the beat where m_valid & m_ready & m_last; 0 otherwise.
- Accept: frame_vld & frame_rdy at edge N. All 640 bits latch into the internal frame buffer. State goes to STREAM. At N+1: m_valid=1, m_bin=0, m_power=power(bin0), m_last=0.
- Beat advances only on m_valid & m_ready. The next beat's m_bin, m_power and m_last are registered at that edge. When m_ready=0, outputs hold stable with m_valid kept high (AXI-style; no retraction).
- m_last=1 exactly when m_bin=15.
- Last-beat handshake without a new frame: m_valid=0 next cycle, state goes to IDLE.
- Last-beat handshake together with frame_vld: the new frame is captured. The next cycle shows bin0 of the new frame with no bubble; state stays STREAM.
- frame_vld while frame_rdy=0 is ignored. bin_in is not sampled and the buffer is unchanged.
- Arithmetic: re and im are sign-extended and squared, giving 39-bit unsigned results (max 2^38). Their sum is 40 bits (max 2^39, no overflow). Shift right by SHIFT with truncation; the result is exactly PW bits.
- Throughput: 16 beats per frame at full ready. Frame-to-frame period is 16 cycles at minimum.
- Reset mid-stream: rst at any edge discards the current frame and clears outputs, so m_valid=0 the next cycle. A frame_vld coincident with rst is not accepted. frame_rdy=1 from the first cycle after rst deasserts.

Optional Feature:
Macro FFT16_PEAK_EN.
- Defined: a running max of power and index is tracked across beats in a frame.
- Ties resolve to the lowest index; strict greater-than compare in bin order.
- On the edge of the bin-15 handshake, peak_bin and peak_power are registered and peak_vld pulses for exactly one cycle.
- The running max is cleared at frame accept and on rst.
- Not defined: the peak_vld, peak_bin and peak_power ports and the logic behind them do not exist.

Test Plan:
- Bin k = {im=k, re=k}, k=0..15, SHIFT=0, m_ready=1, frame_vld pulse -> m_valid at next cycle; 16 consecutive beats with m_power = 2k^2 (0,2,8,...,450); m_last only on beat 15; then m_valid=0.
- Bin 3 = {im=20'h00004, re=20'h00003}, bin 0 = {0, 20'h80000}, bin 1 = {20'h80000, 20'h80000} -> m_power 25, 40'h40_0000_0000, 40'h80_0000_0000. With SHIFT=8: 0, 40'h40_0000_0000>>8 = 32'h4000_0000, 32'h8000_0000.
- Backpressure: m_ready toggling 1,0,0,1 from beat 2 onward -> m_bin/m_power stable while m_ready=0; no bin skipped or duplicated; frame_rdy stays 0.
- Back-to-back frames: hold frame_vld=1 with frame B presented -> beat 15 of A is followed immediately by bin 0 of B; 32 beats in 32 cycles.
- rst asserted at beat 7 -> m_valid=0 the next cycle, frame_rdy=1 after release; a new frame then streams from bin 0.
- FFT16_PEAK_EN defined, bins 5 and 11 both power 1000, others lower -> after the bin-15 handshake, peak_vld=1 for one cycle with peak_bin=5 and peak_power=1000.
